// File: rtl/pid_pos_ctrl_multi.sv
// pid_pos_ctrl_multi: time-multiplexed PID position controller for NUM_AXES axes.
// A single signed multiplier is shared by every axis and term; the sequence runs once per
// sample tick. Optional build macro PID_DERIV_FILTER_EN adds a first-order filter on the
// derivative input of each axis.
module pid_pos_ctrl_multi #(
    parameter int NUM_AXES   = 2,
    parameter int POS_W      = 32,
    parameter int GAIN_W     = 16,
    parameter int FRAC_BITS  = 8,
    parameter int OUT_W      = 16,
    parameter int OUT_LIMIT  = 4000,
    parameter int AW_THRESH  = 3900,
    parameter int INT_LIMIT  = 2000000000,
    parameter int DEADBAND   = 100,
    parameter int LEAK_SHIFT = 6,
    parameter int DIVIDER    = 5000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_AXES*POS_W-1:0]    desired_pos,
    input  logic [NUM_AXES*POS_W-1:0]    actual_pos,
    input  logic [NUM_AXES*GAIN_W-1:0]   kp,
    input  logic [NUM_AXES*GAIN_W-1:0]   ki,
    input  logic [NUM_AXES*GAIN_W-1:0]   kd,
    output logic [NUM_AXES*OUT_W-1:0]    control_signal,
    output logic [NUM_AXES-1:0]          sat_flag,
    output logic                         busy,
    output logic                         sample_done,
    output logic                         overrun
);
    localparam int AXW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int CW  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int EW  = POS_W + 1;        // raw error / delta width
    localparam int FW  = EW + 1;           // filter difference width
    localparam int PW  = GAIN_W + POS_W + 1;
    localparam int SW  = PW + 2;           // product sum with guard bits
    localparam int OW1 = OUT_W + 1;

    localparam logic signed [EW-1:0]  E_MAX    = {2'b00, {(POS_W-1){1'b1}}};
    localparam logic signed [EW-1:0]  E_MIN    = {2'b11, {(POS_W-1){1'b0}}};
    localparam logic signed [EW-1:0]  I_MAX    = EW'(INT_LIMIT);
    localparam logic signed [EW-1:0]  I_MIN    = EW'(-INT_LIMIT);
    localparam logic signed [EW-1:0]  DB       = EW'(DEADBAND);
    localparam logic signed [OW1-1:0] AW_T     = OW1'(AW_THRESH);
    localparam logic signed [SW-1:0]  O_MAX    = SW'(OUT_LIMIT);
    localparam logic signed [SW-1:0]  O_MIN    = SW'(-OUT_LIMIT);
    localparam logic [CW-1:0]         CNT_LAST = CW'(DIVIDER - 1);

    typedef enum logic [3:0] {
        StIdle, StLatch, StErr, StMulP, StMulI, StMulD, StSum, StSat, StDone
    } state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [AXW-1:0]            r_axis;
    logic                      r_busy, r_sample_done, r_overrun;
    logic signed [POS_W-1:0]   r_des   [NUM_AXES];
    logic signed [POS_W-1:0]   r_act   [NUM_AXES];
    logic signed [GAIN_W-1:0]  r_kp    [NUM_AXES];
    logic signed [GAIN_W-1:0]  r_ki    [NUM_AXES];
    logic signed [GAIN_W-1:0]  r_kd    [NUM_AXES];
    logic signed [POS_W-1:0]   r_integ [NUM_AXES];
    logic signed [POS_W-1:0]   r_prev  [NUM_AXES];
    logic signed [OUT_W-1:0]   r_ctrl  [NUM_AXES];
    logic [NUM_AXES-1:0]       r_sat;
    logic signed [POS_W-1:0]   r_e;
    logic signed [EW-1:0]      r_delta;
    logic signed [PW-1:0]      r_prod_p, r_prod_i, r_prod_d;
    logic signed [SW-1:0]      r_sum;
`ifdef PID_DERIV_FILTER_EN
    logic signed [EW-1:0]      r_df    [NUM_AXES];
    logic signed [FW-1:0]      w_fdiff;
    logic signed [EW-1:0]      w_df_next;
`endif

    logic                      w_tick;
    logic signed [EW-1:0]      w_e_raw, w_delta_raw, w_delta, w_e_abs, w_integ_sum;
    logic signed [POS_W-1:0]   w_e, w_integ_next;
    logic signed [OW1-1:0]     w_ctrl_x, w_ctrl_abs;
    logic signed [GAIN_W-1:0]  w_mul_a;
    logic signed [EW-1:0]      w_mul_b;
    logic signed [PW-1:0]      w_prod;
    logic signed [SW-1:0]      w_sum_full;
    logic signed [OUT_W-1:0]   w_sat_val;
    logic                      w_sat;

    assign w_tick = enable && (r_cnt == '0);

    // Error, derivative input and next integral for the axis currently in service
    always_comb begin
        w_e_raw = EW'(r_des[r_axis]) - EW'(r_act[r_axis]);
        w_e     = w_e_raw[POS_W-1:0];
        if (w_e_raw > E_MAX) begin
            w_e = {1'b0, {(POS_W-1){1'b1}}};
        end else if (w_e_raw < E_MIN) begin
            w_e = {1'b1, {(POS_W-1){1'b0}}};
        end
        w_delta_raw = EW'(w_e) - EW'(r_prev[r_axis]);
`ifdef PID_DERIV_FILTER_EN
        w_fdiff   = FW'(w_delta_raw) - FW'(r_df[r_axis]);
        w_df_next = r_df[r_axis] + EW'(w_fdiff >>> 2);
        w_delta   = w_df_next;
`else
        w_delta   = w_delta_raw;
`endif
        w_ctrl_x    = OW1'(r_ctrl[r_axis]);
        w_ctrl_abs  = w_ctrl_x[OW1-1] ? -w_ctrl_x : w_ctrl_x;
        w_e_abs     = w_e[POS_W-1] ? -EW'(w_e) : EW'(w_e);
        w_integ_sum = EW'(r_integ[r_axis]) + EW'(w_e);
        // Anti-windup hold beats deadband leak beats normal accumulation
        if (w_ctrl_abs >= AW_T) begin
            w_integ_next = r_integ[r_axis];
        end else if (w_e_abs < DB) begin
            w_integ_next = r_integ[r_axis] - (r_integ[r_axis] >>> LEAK_SHIFT);
        end else if (w_integ_sum > I_MAX) begin
            w_integ_next = I_MAX[POS_W-1:0];
        end else if (w_integ_sum < I_MIN) begin
            w_integ_next = I_MIN[POS_W-1:0];
        end else begin
            w_integ_next = w_integ_sum[POS_W-1:0];
        end
    end

    // Shared multiplier operand select, product sum and output clamp
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            StMulP: begin w_mul_a = r_kp[r_axis]; w_mul_b = EW'(r_e); end
            StMulI: begin w_mul_a = r_ki[r_axis]; w_mul_b = EW'(r_integ[r_axis]); end
            StMulD: begin w_mul_a = r_kd[r_axis]; w_mul_b = r_delta; end
            default: ;
        endcase
        w_prod     = PW'(w_mul_a) * PW'(w_mul_b);
        w_sum_full = SW'(r_prod_p) + SW'(r_prod_i) + SW'(r_prod_d);
        w_sat      = 1'b1;
        if (r_sum > O_MAX) begin
            w_sat_val = OUT_W'(OUT_LIMIT);
        end else if (r_sum < O_MIN) begin
            w_sat_val = OUT_W'(-OUT_LIMIT);
        end else begin
            w_sat_val = r_sum[OUT_W-1:0];
            w_sat     = 1'b0;
        end
    end

    // Tick counter, sequencer and per-axis loop state
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_axis        <= '0;
            r_busy        <= 1'b0;
            r_sample_done <= 1'b0;
            r_sat         <= '0;
            for (int k = 0; k < NUM_AXES; k++) begin
                r_integ[k] <= '0;
                r_prev[k]  <= '0;
                r_ctrl[k]  <= '0;
`ifdef PID_DERIV_FILTER_EN
                r_df[k]    <= '0;
`endif
            end
            if (reset) r_overrun <= 1'b0;
        end else begin
            r_cnt         <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
            r_sample_done <= 1'b0;
            if (w_tick && (r_state != StIdle)) r_overrun <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (w_tick) begin
                        r_state <= StLatch;
                        r_busy  <= 1'b1;
                    end
                end
                StLatch: begin
                    for (int k = 0; k < NUM_AXES; k++) begin
                        r_des[k] <= desired_pos[k*POS_W +: POS_W];
                        r_act[k] <= actual_pos[k*POS_W +: POS_W];
                        r_kp[k]  <= kp[k*GAIN_W +: GAIN_W];
                        r_ki[k]  <= ki[k*GAIN_W +: GAIN_W];
                        r_kd[k]  <= kd[k*GAIN_W +: GAIN_W];
                    end
                    r_axis  <= '0;
                    r_state <= StErr;
                end
                StErr: begin
                    r_e              <= w_e;
                    r_delta          <= w_delta;
                    r_integ[r_axis]  <= w_integ_next;
`ifdef PID_DERIV_FILTER_EN
                    r_df[r_axis]     <= w_df_next;
`endif
                    r_state          <= StMulP;
                end
                StMulP: begin r_prod_p <= w_prod; r_state <= StMulI; end
                StMulI: begin r_prod_i <= w_prod; r_state <= StMulD; end
                StMulD: begin r_prod_d <= w_prod; r_state <= StSum;  end
                StSum: begin
                    r_sum   <= w_sum_full >>> FRAC_BITS;
                    r_state <= StSat;
                end
                StSat: begin
                    r_ctrl[r_axis] <= w_sat_val;
                    r_sat[r_axis]  <= w_sat;
                    r_prev[r_axis] <= r_e;
                    if (r_axis == AXW'(NUM_AXES - 1)) begin
                        r_state       <= StDone;
                        r_sample_done <= 1'b1;
                    end else begin
                        r_axis  <= r_axis + AXW'(1);
                        r_state <= StErr;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Pack per-axis outputs, axis 0 in the LSBs
    always_comb begin
        control_signal = '0;
        for (int k = 0; k < NUM_AXES; k++) begin
            control_signal[k*OUT_W +: OUT_W] = r_ctrl[k];
        end
    end

    assign sat_flag    = r_sat;
    assign busy        = r_busy;
    assign sample_done = r_sample_done;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_pid_pos_ctrl_multi.sv
// Self-checking bench for pid_pos_ctrl_multi: directed and random samples compared against
// a plain-arithmetic reference of the control law, plus abort and overrun scenarios.
module tb_pid_pos_ctrl_multi;
    localparam int NA = 2;
    localparam int PW = 32;
    localparam int GW = 16;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic reset, enable, reset2, enable2;
    logic [NA*PW-1:0] desired_pos, actual_pos;
    logic [NA*GW-1:0] kp, ki, kd;
    logic [NA*OW-1:0] control_signal, control_signal2;
    logic [NA-1:0]    sat_flag, sat_flag2;
    logic             busy, sample_done, overrun, busy2, sample_done2, overrun2;

    int checks = 0;
    int errors = 0;

    longint des [NA], act [NA], g_p [NA], g_i [NA], g_d [NA];
    longint m_integ [NA], m_prev [NA], m_ctrl [NA], m_df [NA], m_sat [NA];

    always #5 clk = ~clk;

    pid_pos_ctrl_multi #(.DIVIDER(20)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .desired_pos(desired_pos), .actual_pos(actual_pos),
        .kp(kp), .ki(ki), .kd(kd),
        .control_signal(control_signal), .sat_flag(sat_flag),
        .busy(busy), .sample_done(sample_done), .overrun(overrun)
    );

    pid_pos_ctrl_multi #(.DIVIDER(10)) dut_ovr (
        .clk(clk), .reset(reset2), .enable(enable2),
        .desired_pos(desired_pos), .actual_pos(actual_pos),
        .kp(kp), .ki(ki), .kd(kd),
        .control_signal(control_signal2), .sat_flag(sat_flag2),
        .busy(busy2), .sample_done(sample_done2), .overrun(overrun2)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint ctrl_of(input logic [NA*OW-1:0] bus, input int k);
        logic signed [OW-1:0] v;
        v = bus[k*OW +: OW];
        return longint'(v);
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint rnd_range(input int lo, input int hi);
        return longint'(lo) + longint'($urandom_range(0, hi - lo));
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < NA; k++) begin
            desired_pos[k*PW +: PW] = des[k][PW-1:0];
            actual_pos[k*PW +: PW]  = act[k][PW-1:0];
            kp[k*GW +: GW]          = g_p[k][GW-1:0];
            ki[k*GW +: GW]          = g_i[k][GW-1:0];
            kd[k*GW +: GW]          = g_d[k][GW-1:0];
        end
    endtask

    task automatic zero_inputs();
        for (int k = 0; k < NA; k++) begin
            des[k] = 0; act[k] = 0; g_p[k] = 0; g_i[k] = 0; g_d[k] = 0;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NA; k++) begin
            m_integ[k] = 0; m_prev[k] = 0; m_ctrl[k] = 0; m_df[k] = 0; m_sat[k] = 0;
        end
    endtask

    // Reference control law for one sample, all axes
    task automatic model_sample();
        longint e, delta, s;
        for (int k = 0; k < NA; k++) begin
            e = des[k] - act[k];
            if (e > 64'sd2147483647) e = 64'sd2147483647;
            if (e < -64'sd2147483648) e = -64'sd2147483648;
            delta = e - m_prev[k];
`ifdef PID_DERIV_FILTER_EN
            m_df[k] = m_df[k] + ((delta - m_df[k]) >>> 2);
            delta = m_df[k];
`endif
            if (labs(m_ctrl[k]) >= 3900) begin
                m_integ[k] = m_integ[k];
            end else if (labs(e) < 100) begin
                m_integ[k] = m_integ[k] - (m_integ[k] >>> 6);
            end else begin
                m_integ[k] = m_integ[k] + e;
                if (m_integ[k] > 2000000000) m_integ[k] = 2000000000;
                if (m_integ[k] < -2000000000) m_integ[k] = -2000000000;
            end
            s = (g_p[k] * e + g_i[k] * m_integ[k] + g_d[k] * delta) >>> 8;
            m_sat[k] = (s > 4000 || s < -4000) ? 1 : 0;
            m_ctrl[k] = (s > 4000) ? 4000 : ((s < -4000) ? -4000 : s);
            m_prev[k] = e;
        end
    endtask

    // One sample: first=1 means enable rises now, so the tick is the next edge
    task automatic do_sample(input bit first, input string tag);
        int n;
        bit seen;
        apply_inputs();
        model_sample();
        if (first) enable = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (sample_done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_latency"}, longint'(n), first ? 14 : 19);
        for (int k = 0; k < NA; k++) begin
            chk($sformatf("%s_ctrl%0d", tag, k), ctrl_of(control_signal, k), m_ctrl[k]);
            chk($sformatf("%s_sat%0d", tag, k), longint'(sat_flag[k]), m_sat[k]);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, longint'(sample_done), 0);
        chk({tag, "_idle"}, longint'(busy), 0);
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        zero_inputs();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; reset2 = 1'b1; enable2 = 1'b0;
        zero_inputs();
        model_clear();
        apply_inputs();
        repeat (3) @(negedge clk);
        chk("rst_ctrl0", ctrl_of(control_signal, 0), 0);
        chk("rst_ctrl1", ctrl_of(control_signal, 1), 0);
        chk("rst_sat", longint'(sat_flag), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(sample_done), 0);
        chk("rst_overrun", longint'(overrun), 0);
        reset = 1'b0; enable = 1'b0;
        @(negedge clk);

        // Proportional only, then saturation both ways on axis 1
        des[0] = 1000; g_p[0] = 256;
        do_sample(1'b1, "p_basic");
        chk("p_basic_const", ctrl_of(control_signal, 0), 1000);
        des[1] = 100000; g_p[1] = 256;
        do_sample(1'b0, "p_satpos");
        chk("p_satpos_const", ctrl_of(control_signal, 1), 4000);
        chk("p_satpos_flag", longint'(sat_flag[1]), 1);
        des[1] = -100000;
        do_sample(1'b0, "p_satneg");
        chk("p_satneg_const", ctrl_of(control_signal, 1), -4000);

        // Integral ramp up to the anti-windup freeze
        restart();
        g_i[0] = 256; des[0] = 200;
        for (int s = 0; s < 24; s++) begin
            do_sample(s == 0, $sformatf("int%0d", s));
            if (s == 2) chk("int_600", ctrl_of(control_signal, 0), 600);
        end
        chk("int_frozen", ctrl_of(control_signal, 0), 4000);

        // Deadband leak
        restart();
        g_i[0] = 64; des[0] = 3200;
        do_sample(1'b1, "leak_a");
        do_sample(1'b0, "leak_b");
        des[0] = 50;
        do_sample(1'b0, "leak_c");
        chk("leak_const", ctrl_of(control_signal, 0), 1575);

        // Derivative step
        restart();
        g_d[0] = 256;
        do_sample(1'b1, "d_zero");
        des[0] = 500;
        do_sample(1'b0, "d_step");
`ifdef PID_DERIV_FILTER_EN
        chk("d_step_const", ctrl_of(control_signal, 0), 125);
`else
        chk("d_step_const", ctrl_of(control_signal, 0), 500);
`endif
        do_sample(1'b0, "d_after");
`ifdef PID_DERIV_FILTER_EN
        chk("d_after_const", ctrl_of(control_signal, 0), 93);
`else
        chk("d_after_const", ctrl_of(control_signal, 0), 0);
`endif

        // Reset in the middle of axis 0 MUL_I
        restart();
        g_p[0] = 256; g_i[0] = 256; des[0] = 1000;
        g_p[1] = 128; des[1] = -3000;
        do_sample(1'b1, "mid_a");
        repeat (9) @(negedge clk);
        chk("mid_busy", longint'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_busy", longint'(busy), 0);
        chk("rmid_ctrl0", ctrl_of(control_signal, 0), 0);
        chk("rmid_ctrl1", ctrl_of(control_signal, 1), 0);
        reset = 1'b0;
        model_clear();
        do_sample(1'b1, "post_rst");

        // Enable dropped during axis 0 ERR
        repeat (7) @(negedge clk);
        chk("emid_busy_before", longint'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("emid_busy", longint'(busy), 0);
        chk("emid_ctrl0", ctrl_of(control_signal, 0), 0);
        chk("emid_ctrl1", ctrl_of(control_signal, 1), 0);
        model_clear();
        do_sample(1'b1, "post_en");

        // Randomised samples
        restart();
        for (int s = 0; s < 40; s++) begin
            if (s % 8 == 0) begin
                for (int k = 0; k < NA; k++) begin
                    g_p[k] = rnd_range(-512, 512);
                    g_i[k] = rnd_range(-64, 64);
                    g_d[k] = rnd_range(-256, 256);
                end
            end
            for (int k = 0; k < NA; k++) begin
                case ($urandom_range(0, 3))
                    0: begin
                        des[k] = longint'($signed($urandom));
                        act[k] = longint'($signed($urandom));
                    end
                    1: begin
                        des[k] = rnd_range(-20000, 20000);
                        act[k] = rnd_range(-20000, 20000);
                    end
                    2: begin
                        act[k] = rnd_range(-20000, 20000);
                        des[k] = act[k] + rnd_range(-99, 99);
                    end
                    default: ;
                endcase
            end
            do_sample(s == 0, $sformatf("rnd%0d", s));
        end
        chk("no_overrun", longint'(overrun), 0);

        // Overrun on the short-divider instance
        reset2 = 1'b0; enable2 = 1'b1;
        repeat (5) @(negedge clk);
        chk("ovr_first", longint'(overrun2), 0);
        chk("ovr_busy", longint'(busy2), 1);
        repeat (7) @(negedge clk);
        chk("ovr_second", longint'(overrun2), 1);
        enable2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovr_hold", longint'(overrun2), 1);
        chk("ovr_en_busy", longint'(busy2), 0);
        chk("ovr_en_ctrl0", ctrl_of(control_signal2, 0), 0);
        reset2 = 1'b1;
        @(negedge clk);
        chk("ovr_reset", longint'(overrun2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
